branch_predictor: RTL and testbench

- Per-PC 2-bit saturating-counter branch history table (BHT) that predicts conditional branches in fetch.
- It is trained at execute by the taken/not-taken outcome (pc_sel) from branch_controller, so it is the predicting end of the branch-resolution interface.
- Flags a mispredict one cycle after resolution so the core can flush and redirect.
- Table contents are initialised by a walk state machine after reset or on a clear request.

---
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: per-PC 2-bit saturating-counter BHT with init walk and 1-cycle mispredict flag.
// Optional BP_STATS_EN adds saturating branch/mispredict statistics counters.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    output logic        ready,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_pred_taken,
    output logic        mispredict
`ifdef BP_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] walk_ptr, walk_next;
    logic [1:0]       bht [ENTRIES];
    logic [IDX_W-1:0] lookup_idx, upd_idx;
    logic             run, upd_en, miss;
    logic [1:0]       upd_cnt, upd_new;
    logic             unused_pc_bits;

    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign run        = (state == RUN);
    assign ready      = run;
    // A clear in RUN wins over a same-cycle update
    assign upd_en     = run & upd_valid & ~clear;
    assign miss       = run & upd_valid & (upd_taken != upd_pred_taken);
    assign upd_cnt    = bht[upd_idx];
    assign upd_new    = upd_taken ? (&upd_cnt ? upd_cnt : upd_cnt + 2'd1)
                                  : (|upd_cnt ? upd_cnt - 2'd1 : upd_cnt);
    assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                              upd_pc[31:IDX_W+2], upd_pc[1:0]};

    always_comb begin
        state_next = state;
        walk_next  = walk_ptr;
        if (clear) begin
            state_next = INIT;
            walk_next  = '0;
        end else if (state == INIT) begin
            walk_next  = walk_ptr + IDX_W'(1);
            state_next = (walk_ptr == LAST) ? RUN : INIT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            walk_ptr <= '0;
        end else begin
            state    <= state_next;
            walk_ptr <= walk_next;
        end
    end

    // Table has no reset; the INIT walk brings every entry to weak-NT
    always_ff @(posedge clk) begin
        if (!run)
            bht[walk_ptr] <= 2'b01;
        else if (upd_en)
            bht[upd_idx] <= upd_new;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            pred_valid <= lookup_valid;
            pred_taken <= lookup_valid & run & bht[lookup_idx][1];
            mispredict <= miss;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (clear) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (run & upd_valid & ~&stat_branches)
                stat_branches <= stat_branches + STAT_W'(1);
            if (miss & ~&stat_mispredicts)
                stat_mispredicts <= stat_mispredicts + STAT_W'(1);
        end
    end
`else
    logic [STAT_W-1:0] unused_stat_w;
    assign unused_stat_w = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table-driven directed checks of branch_predictor plus
// hand-written sequences for init walk, clear and mid-walk reset.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset_n, clear, ready;
    logic        lookup_valid, pred_valid, pred_taken;
    logic [31:0] lookup_pc, upd_pc;
    logic        upd_valid, upd_taken, upd_pred_taken, mispredict;
`ifdef BP_STATS_EN
    logic [15:0] stat_branches, stat_mispredicts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .ready(ready),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_pred_taken(upd_pred_taken), .mispredict(mispredict)
`ifdef BP_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        upt;
        logic        pv;
        logic        pt;
        logic        mp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 0; lookup_valid = 0; lookup_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_pred_taken = 0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (ready) break;
        end
    endtask

    function automatic vec_t mk(logic lv, logic [31:0] lpc, logic uv, logic [31:0] upc,
                                logic ut, logic upt, logic pv, logic pt, logic mp);
        vec_t v;
        v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.upt = upt;
        v.pv = pv; v.pt = pt; v.mp = mp;
        return v;
    endfunction

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // All entries start weak-NT after the walk; 0x40/0x80 alias index 0
        vecs.push_back(mk(1, 32'h0,  0, 0,     0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,      1, 32'h40, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,      1, 32'h40, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,      0, 0,     0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h40, 0, 0,     0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h80, 0, 0,     0, 0, 1, 1, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 32'h44, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,      1, 32'h44, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 32'h44, 0, 0,     0, 0, 1, 1, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 32'h44, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,      1, 32'h44, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h44, 0, 0,     0, 0, 1, 0, 0));
        // Read-before-write on index 2, then the committed value
        vecs.push_back(mk(1, 32'h48, 1, 32'h48, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 32'h48, 0, 0,     0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h4B, 0, 0,     0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h10000048, 1, 32'h4C, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h40, 0, 0,     0, 0, 1, 1, 0));

        idle();
        reset_n = 0;
        #1;
        check("reset_ready", ready, 0);
        check("reset_pred_valid", pred_valid, 0);
        check("reset_pred_taken", pred_taken, 0);
        check("reset_mispredict", mispredict, 0);
`ifdef BP_STATS_EN
        check("reset_stat_branches", stat_branches, 0);
        check("reset_stat_mispredicts", stat_mispredicts, 0);
`endif
        #16 reset_n = 1;
        check("ready_low_after_release", ready, 0);
        wait_ready(n);
        check("init_cycles_after_reset", n, 16);

        foreach (vecs[i]) begin
            lookup_valid = vecs[i].lv; lookup_pc = vecs[i].lpc;
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc;
            upd_taken = vecs[i].ut; upd_pred_taken = vecs[i].upt;
            tick();
            check($sformatf("vec%0d_pred_valid", i), pred_valid, vecs[i].pv);
            check($sformatf("vec%0d_pred_taken", i), pred_taken, vecs[i].pt);
            check($sformatf("vec%0d_mispredict", i), mispredict, vecs[i].mp);
        end
        idle();

`ifdef BP_STATS_EN
        // Bench-side tallies of the RUN updates issued by the vector table
        begin
            int b = 0, m = 0;
            foreach (vecs[i]) if (vecs[i].uv) begin b++; if (vecs[i].ut != vecs[i].upt) m++; end
            check("stat_branches_vectors", stat_branches, b);
            check("stat_mispredicts_vectors", stat_mispredicts, m);
        end
`endif

        // Clear in RUN; taken updates during the walk must be ignored
        clear = 1;
        tick();
        check("ready_low_after_clear", ready, 0);
`ifdef BP_STATS_EN
        check("stat_branches_cleared", stat_branches, 0);
        check("stat_mispredicts_cleared", stat_mispredicts, 0);
`endif
        clear = 0;
        lookup_valid = 1; lookup_pc = 32'h40;
        upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_pred_taken = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            check($sformatf("walk%0d_mispredict", i), mispredict, 0);
            check($sformatf("walk%0d_pred_valid", i), pred_valid, 1);
            check($sformatf("walk%0d_pred_taken", i), pred_taken, 0);
            if (ready) break;
        end
        check("init_cycles_after_clear", n, 16);
        idle();
        lookup_valid = 1; lookup_pc = 32'h40;
        tick();
        check("post_clear_lookup_valid", pred_valid, 1);
        check("post_clear_lookup_taken", pred_taken, 0);
        idle();

        // Reset mid-walk restarts the full walk
        clear = 1;
        tick();
        clear = 0;
        for (int i = 0; i < 7; i++) tick();
        check("mid_walk_not_ready", ready, 0);
        lookup_valid = 1;
        tick();
        check("mid_walk_pred_valid_pre", pred_valid, 1);
        reset_n = 0;
        #1;
        check("mid_walk_reset_pred_valid", pred_valid, 0);
        check("mid_walk_reset_ready", ready, 0);
        #1 reset_n = 1;
        idle();
        wait_ready(n);
        check("init_cycles_after_mid_reset", n, 16);

`ifdef BP_STATS_EN
        upd_valid = 1; upd_pc = 32'h50; upd_taken = 1; upd_pred_taken = 1;
        tick();
        upd_taken = 0; upd_pred_taken = 0;
        tick();
        upd_taken = 1; upd_pred_taken = 0;
        tick();
        idle();
        tick();
        check("stat_branches_3", stat_branches, 3);
        check("stat_mispredicts_1", stat_mispredicts, 1);
        clear = 1;
        tick();
        clear = 0;
        check("stat_branches_clear", stat_branches, 0);
        check("stat_mispredicts_clear", stat_mispredicts, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
